// File: rtl/score_keeper.sv
// score_keeper: tracks game score and session high score, and feeds the two-digit display
module score_keeper #(
    parameter int MAX_SCORE   = 99,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       point,
    input  logic       game_over,
    output logic [7:0] number,
    output logic       change_score,
    output logic       new_record,
    output logic       playing
);
    localparam int HW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, PLAYING, OVER_SCORE, OVER_HIGH} state_t;

    state_t          state, state_nx;
    logic [6:0]      score, score_nx, high, high_nx, bumped, final_score, present;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic            rec_nx, init, hold_done;

    assign bumped      = (score >= 7'(MAX_SCORE)) ? score : score + 7'd1;
    assign final_score = point ? bumped : score;
    assign hold_done   = hold_cnt == HW'(HOLD_CYCLES - 1);
    assign present     = (state == IDLE || state == OVER_HIGH) ? high : score;
    assign playing     = state == PLAYING;

    always_comb begin
        state_nx = state;
        score_nx = score;
        high_nx  = high;
        hold_nx  = hold_cnt;
        rec_nx   = new_record;
        if (new_game) begin
            state_nx = PLAYING;
            score_nx = '0;
            rec_nx   = 1'b0;
            hold_nx  = '0;
        end else begin
            case (state)
                PLAYING: begin
                    score_nx = final_score;
                    if (game_over) begin
                        state_nx = OVER_SCORE;
                        hold_nx  = '0;
                        high_nx  = (final_score > high) ? final_score : high;
                        rec_nx   = final_score > high;
                    end
                end
                OVER_SCORE: begin
                    state_nx = hold_done ? OVER_HIGH : OVER_SCORE;
                    hold_nx  = hold_done ? '0 : hold_cnt + 1'b1;
                end
                OVER_HIGH: begin
                    state_nx = hold_done ? OVER_SCORE : OVER_HIGH;
                    hold_nx  = hold_done ? '0 : hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // number lags the state registers by one edge; init forces a load on the first edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            score        <= '0;
            high         <= '0;
            hold_cnt     <= '0;
            new_record   <= 1'b0;
            number       <= '0;
            change_score <= 1'b0;
            init         <= 1'b1;
        end else begin
            state        <= state_nx;
            score        <= score_nx;
            high         <= high_nx;
            hold_cnt     <= hold_nx;
            new_record   <= rec_nx;
            number       <= {1'b0, present};
            change_score <= init || ({1'b0, present} != number);
            init         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized + directed scoreboard bench against a cycle-count reference model
module tb_score_keeper;
    localparam int MAX  = 99;
    localparam int HOLD = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       new_game = 1'b0, point = 1'b0, game_over = 1'b0;
    logic [7:0] number;
    logic       change_score, new_record, playing;

    score_keeper #(.MAX_SCORE(MAX), .HOLD_CYCLES(HOLD)) dut (
        .clock(clock), .reset_n(reset_n), .new_game(new_game), .point(point),
        .game_over(game_over), .number(number), .change_score(change_score),
        .new_record(new_record), .playing(playing)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] num;
        logic       chg;
        logic       rec;
        logic       play;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // reference model: mode 0 idle, 1 playing, 2 game over; over_t = edges since game over
    int   m_mode, m_score, m_high, m_over_t, m_num;
    bit   m_rec, m_init;

    function automatic int shown();
        if (m_mode == 0) return m_high;
        if (m_mode == 1) return m_score;
        return ((m_over_t / HOLD) % 2 == 1) ? m_high : m_score;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_high = 0; m_over_t = 0; m_num = 0;
        m_rec = 0; m_init = 1;
    endtask

    task automatic step(input bit rn, input bit ng, input bit pt, input bit go);
        exp_t e;
        int   v;
        @(negedge clock);
        reset_n = rn; new_game = ng; point = pt; game_over = go;
        if (!rn) begin
            model_reset();
            e = '0;
        end else begin
            v     = shown();
            e.chg = m_init || (v != m_num);
            e.num = 8'(v);
            m_num = v;
            m_init = 0;
            if (ng) begin
                m_mode = 1; m_score = 0; m_rec = 0;
            end else if (m_mode == 1) begin
                if (pt && m_score < MAX) m_score++;
                if (go) begin
                    m_mode = 2; m_over_t = 0;
                    if (m_score > m_high) begin m_high = m_score; m_rec = 1; end
                end
            end else if (m_mode == 2) begin
                m_over_t++;
            end
            e.rec  = m_rec;
            e.play = m_mode == 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) begin step(1, 0, 1, 0); step(1, 0, 0, 0); end
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if ({number, change_score, new_record, playing} !== 11'd0) begin
            mismatched++;
            $display("FAIL async_reset: got number=%0d chg=%b rec=%b play=%b, want all 0",
                     number, change_score, new_record, playing);
        end
        model_reset();
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if ({number, change_score, new_record, playing} !== e) begin
                mismatched++;
                $display("FAIL cycle t=%0t: got number=%0d chg=%b rec=%b play=%b, want number=%0d chg=%b rec=%b play=%b",
                         $time, number, change_score, new_record, playing, e.num, e.chg, e.rec, e.play);
            end
        end
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(3);
        step(1, 1, 0, 0); idle(1);
        points(3);
        step(1, 0, 0, 1); idle(12);
        step(1, 1, 0, 0); points(2);
        step(1, 0, 0, 1); idle(20);
        step(1, 1, 0, 0); points(100);
        step(1, 0, 0, 1); idle(10);
        async_reset();
        step(0, 0, 0, 0); step(1, 0, 0, 0); idle(2);
        step(1, 1, 0, 0); points(5); step(1, 0, 0, 1); idle(3);
        step(1, 1, 0, 0); points(5); step(1, 0, 1, 1); idle(10);
        step(1, 1, 0, 1); idle(3);
        for (int i = 0; i < 2000; i++)
            step(1, $urandom_range(39) == 0, $urandom_range(2) == 0, $urandom_range(19) == 0);
        step(1, 1, 0, 0); points(4); step(1, 0, 0, 1); idle(6);
        async_reset();
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); idle(5);
        @(posedge clock);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
